// File: rtl/systolic_array_gen.sv
// Output-stationary systolic matrix-multiply engine: C = A * B, with operands streamed from
// synchronous scratchpads, skewed per row/column, and C drained row by row over valid/ready.

module systolic_pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic              signed_mode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);
  logic [ACC_W-1:0] a_x, b_x;

  always_comb begin
    if (signed_mode) begin
      a_x = ACC_W'($signed(a));
      b_x = ACC_W'($signed(b));
    end else begin
      a_x = ACC_W'(a);
      b_x = ACC_W'(b);
    end
  end

  // Product truncated to ACC_W, so the running sum wraps modulo 2^ACC_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc + a_x * b_x;
  end
endmodule

module systolic_array_gen #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int K_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [K_W-1:0]           k_len,
  input  logic                     signed_mode,
  input  logic                     acc_mode,
  output logic [K_W-1:0]           a_addr,
  input  logic [ROWS*DATA_W-1:0]   a_data,
  output logic [K_W-1:0]           b_addr,
  input  logic [COLS*DATA_W-1:0]   b_data,
  output logic [$clog2(ROWS)-1:0]  c_addr,
  output logic [COLS*ACC_W-1:0]    c_data,
  output logic                     c_valid,
  input  logic                     c_ready,
  output logic                     busy,
  output logic                     done
);
  localparam int TW = K_W + $clog2(ROWS + COLS) + 1;
  localparam int RW = $clog2(ROWS);
  localparam logic [2:0] S_IDLE = 3'd0, S_FEED = 3'd1, S_DRAIN = 3'd2, S_WRITE = 3'd3, S_DONE = 3'd4;

  logic [2:0]    state;
  logic [TW-1:0] t, t_last;
  logic [K_W-1:0] k_cap;
  logic          sm_cap, feed_vld, go, feed_en, clr_acc;

  assign go      = (state == S_IDLE) && start;
  assign feed_en = (state == S_FEED);
  assign clr_acc = go && !acc_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE; t <= '0; t_last <= '0; k_cap <= '0; sm_cap <= 1'b0;
      a_addr <= '0; b_addr <= '0; c_addr <= '0; feed_vld <= 1'b0;
    end else begin
      // Read data for address t lands one cycle later; flag it so t >= k_len injects zeros.
      feed_vld <= feed_en && (t < TW'(k_cap));
      case (state)
        S_IDLE: if (start) begin
          k_cap  <= k_len;
          sm_cap <= signed_mode;
          t      <= '0;
          t_last <= TW'(k_len) + TW'(ROWS + COLS - 2);
          a_addr <= '0;
          b_addr <= '0;
          c_addr <= '0;
          state  <= S_FEED;
        end
        S_FEED: begin
          if (t + TW'(1) < TW'(k_cap)) begin
            a_addr <= K_W'(t + TW'(1));
            b_addr <= K_W'(t + TW'(1));
          end
          if (t == t_last) state <= S_DRAIN;
          else             t <= t + TW'(1);
        end
        S_DRAIN: state <= S_WRITE;
        S_WRITE: if (c_ready) begin
          if (c_addr == RW'(ROWS - 1)) begin
            c_addr <= '0;
            state  <= S_DONE;
          end else begin
            c_addr <= c_addr + RW'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  logic [ROWS-1:0][DATA_W-1:0]            a_edge;
  logic [COLS-1:0][DATA_W-1:0]            b_edge;
  logic [ROWS-1:0][COLS-1:0][DATA_W-1:0]  a_pe, b_pe;
  logic [ROWS-1:0][COLS-2:0][DATA_W-1:0]  a_pipe;
  logic [ROWS-2:0][COLS-1:0][DATA_W-1:0]  b_pipe;
  logic [ROWS-1:0][COLS-1:0][ACC_W-1:0]   acc;

  // Row i / column j enter through an i / j deep delay line so operands meet on the diagonal.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_askew
    logic [DATA_W-1:0] raw;
    assign raw = feed_vld ? a_data[(ROWS-gi)*DATA_W-1 -: DATA_W] : '0;
    if (gi == 0) begin : g_d0
      assign a_edge[gi] = raw;
    end else begin : g_dn
      logic [gi-1:0][DATA_W-1:0] sr;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       sr <= '0;
        else if (go)      sr <= '0;
        else if (feed_en) begin
          sr[0] <= raw;
          for (int k = 1; k < gi; k++) sr[k] <= sr[k-1];
        end
      end
      assign a_edge[gi] = sr[gi-1];
    end
  end

  for (genvar gj = 0; gj < COLS; gj++) begin : g_bskew
    logic [DATA_W-1:0] raw;
    assign raw = feed_vld ? b_data[(COLS-gj)*DATA_W-1 -: DATA_W] : '0;
    if (gj == 0) begin : g_d0
      assign b_edge[gj] = raw;
    end else begin : g_dn
      logic [gj-1:0][DATA_W-1:0] sr;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       sr <= '0;
        else if (go)      sr <= '0;
        else if (feed_en) begin
          sr[0] <= raw;
          for (int k = 1; k < gj; k++) sr[k] <= sr[k-1];
        end
      end
      assign b_edge[gj] = sr[gj-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_pipe <= '0;
      b_pipe <= '0;
    end else if (go) begin
      a_pipe <= '0;
      b_pipe <= '0;
    end else if (feed_en) begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS - 1; j++) a_pipe[i][j] <= a_pe[i][j];
      for (int i = 0; i < ROWS - 1; i++)
        for (int j = 0; j < COLS; j++) b_pipe[i][j] <= b_pe[i][j];
    end
  end

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_col
      if (gj == 0) begin : g_al
        assign a_pe[gi][gj] = a_edge[gi];
      end else begin : g_ai
        assign a_pe[gi][gj] = a_pipe[gi][gj-1];
      end
      if (gi == 0) begin : g_bt
        assign b_pe[gi][gj] = b_edge[gj];
      end else begin : g_bi
        assign b_pe[gi][gj] = b_pipe[gi-1][gj];
      end
      systolic_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk(clk), .rst_n(rst_n), .en(feed_en), .clr(clr_acc), .signed_mode(sm_cap),
        .a(a_pe[gi][gj]), .b(b_pe[gi][gj]), .acc(acc[gi][gj])
      );
    end
  end

  always_comb begin
    c_data = '0;
    if (state == S_WRITE)
      for (int j = 0; j < COLS; j++) c_data[(COLS-j)*ACC_W-1 -: ACC_W] = acc[c_addr][j];
  end

  assign c_valid = (state == S_WRITE);
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
endmodule

// File: tb/tb_systolic_array_gen.sv
// Directed bench for systolic_array_gen: 4x4 array with 32-bit accumulators plus an 8-bit
// accumulator instance for wraparound.

module tb_systolic_array_gen;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0, signed_mode = 1'b0, acc_mode = 1'b0, c_ready = 1'b1;
  logic [7:0]   k_len = '0, a_addr, b_addr;
  logic [31:0]  a_data = '0, b_data = '0;
  logic [1:0]   c_addr;
  logic [127:0] c_data;
  logic         c_valid, busy, done;

  logic         start8 = 1'b0, c_ready8 = 1'b1;
  logic [7:0]   k_len8 = 8'd2, a_addr8, b_addr8;
  logic [31:0]  a_data8 = 32'hFFFF_FFFF, b_data8 = 32'hFFFF_FFFF;
  logic [1:0]   c_addr8;
  logic [31:0]  c_data8;
  logic         c_valid8, busy8, done8;

  logic [31:0]  a_mem [256];
  logic [31:0]  b_mem [256];

  int errors = 0, checks = 0;

  systolic_array_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .signed_mode(signed_mode),
    .acc_mode(acc_mode), .a_addr(a_addr), .a_data(a_data), .b_addr(b_addr), .b_data(b_data),
    .c_addr(c_addr), .c_data(c_data), .c_valid(c_valid), .c_ready(c_ready), .busy(busy), .done(done)
  );

  systolic_array_gen #(.ACC_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .k_len(k_len8), .signed_mode(1'b0),
    .acc_mode(1'b0), .a_addr(a_addr8), .a_data(a_data8), .b_addr(b_addr8), .b_data(b_data8),
    .c_addr(c_addr8), .c_data(c_data8), .c_valid(c_valid8), .c_ready(c_ready8), .busy(busy8), .done(done8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    a_data <= a_mem[a_addr];
    b_data <= b_mem[b_addr];
  end

  // Captured job outcome
  logic [127:0] got [4];
  logic [127:0] h_data;
  logic [1:0]   h_addr;
  int nwr, done_cnt, lat, addr_nz, unstable, vdrop, stall_left, held;
  int poke_at = -1, stall_row = -1, stall_len = 0;
  logic post_done, post_busy;

  function automatic logic [127:0] t1_row(input int r, input int mult);
    logic [127:0] w;
    w = '0;
    for (int j = 0; j < 4; j++) w[(4-j)*32-1 -: 32] = 32'(mult * (r*4 + j + 1));
    return w;
  endfunction

  task automatic load_t1();
    for (int k = 0; k < 256; k++) begin a_mem[k] = '0; b_mem[k] = '0; end
    for (int k = 0; k < 4; k++)
      for (int e = 0; e < 4; e++) begin
        a_mem[k][(4-e)*8-1 -: 8] = (e == k) ? 8'd1 : 8'd0;
        b_mem[k][(4-e)*8-1 -: 8] = 8'(k*4 + e + 1);
      end
  endtask

  task automatic load_fill(input logic [7:0] av, input logic [7:0] bv);
    for (int k = 0; k < 256; k++) begin
      a_mem[k] = {4{av}};
      b_mem[k] = {4{bv}};
    end
  endtask

  // Drives one job and records writes, latency, address activity and handshake behaviour.
  task automatic run_job(input int k, input logic sm, input logic am);
    k_len = 8'(k); signed_mode = sm; acc_mode = am; start = 1'b1; c_ready = 1'b1;
    nwr = 0; done_cnt = 0; lat = -1; addr_nz = 0; unstable = 0; vdrop = 0; held = 0;
    stall_left = stall_len;
    for (int r = 0; r < 4; r++) got[r] = {4{32'hDEAD_BEEF}};
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc < 300 && lat < 0; cyc++) begin
      if (cyc == poke_at) begin
        start = 1'b1; k_len = 8'd1; signed_mode = ~sm; acc_mode = ~am;
      end else begin
        start = 1'b0;
      end
      if (a_addr != 8'd0 || b_addr != 8'd0) addr_nz++;
      if (done) begin lat = cyc; done_cnt++; end
      if (c_valid) begin
        if (held != 0 && (c_addr != h_addr || c_data != h_data)) unstable++;
      end else if (held != 0) begin
        vdrop++;
      end
      c_ready = !(c_valid && int'(c_addr) == stall_row && stall_left > 0);
      if (!c_ready) stall_left--;
      if (c_valid && c_ready) begin
        got[c_addr] = c_data; nwr++; held = 0;
      end else if (c_valid) begin
        held = 1; h_addr = c_addr; h_data = c_data;
      end
      @(negedge clk);
    end
    post_done = done;
    post_busy = busy;
    start = 1'b0; c_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (c_valid !== 1'b0)  begin errors++; $display("FAIL reset_c_valid: got %b expected 0", c_valid); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (a_addr !== 8'd0 || b_addr !== 8'd0)
      begin errors++; $display("FAIL reset_addr: got a=%0h b=%0h expected 0", a_addr, b_addr); end
    checks++; if (c_addr !== 2'd0)   begin errors++; $display("FAIL reset_c_addr: got %0d expected 0", c_addr); end
    checks++; if (c_data !== '0)     begin errors++; $display("FAIL reset_c_data: got %0h expected 0", c_data); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_identity();
    load_t1();
    run_job(4, 1'b0, 1'b0);
    checks++; if (nwr != 4)       begin errors++; $display("FAIL t1_writes: got %0d expected 4", nwr); end
    checks++; if (done_cnt != 1)  begin errors++; $display("FAIL t1_done_count: got %0d expected 1", done_cnt); end
    // done seen after 1 + (K+ROWS+COLS-1) + 1 + ROWS clock edges past the start cycle
    checks++; if (lat != 17)      begin errors++; $display("FAIL t1_latency: got %0d expected 17", lat); end
    checks++; if (post_done !== 1'b0 || post_busy !== 1'b0)
      begin errors++; $display("FAIL t1_done_pulse: got done=%b busy=%b expected 0 0", post_done, post_busy); end
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (got[r] !== t1_row(r, 1)) begin errors++; $display("FAIL t1_row%0d: got %h expected %h", r, got[r], t1_row(r, 1)); end
    end
  endtask

  task automatic test_signed();
    load_fill(8'hFF, 8'hFE);
    run_job(3, 1'b1, 1'b0);
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (got[r] !== {4{32'd6}}) begin errors++; $display("FAIL signed_row%0d: got %h expected %h", r, got[r], {4{32'd6}}); end
    end
    run_job(3, 1'b0, 1'b0);
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (got[r] !== {4{32'd194310}}) begin errors++; $display("FAIL unsigned_row%0d: got %h expected %h", r, got[r], {4{32'd194310}}); end
    end
  endtask

  task automatic test_kzero();
    load_fill(8'h11, 8'h22);
    run_job(0, 1'b0, 1'b0);
    checks++; if (addr_nz != 0)   begin errors++; $display("FAIL k0_addr_moved: got %0d cycles nonzero expected 0", addr_nz); end
    checks++; if (nwr != 4)       begin errors++; $display("FAIL k0_writes: got %0d expected 4", nwr); end
    checks++; if (done_cnt != 1)  begin errors++; $display("FAIL k0_done_count: got %0d expected 1", done_cnt); end
    checks++; if (lat != 13)      begin errors++; $display("FAIL k0_latency: got %0d expected 13", lat); end
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (got[r] !== '0) begin errors++; $display("FAIL k0_row%0d: got %h expected 0", r, got[r]); end
    end
  endtask

  task automatic test_backpressure();
    load_t1();
    stall_row = 2; stall_len = 5;
    run_job(4, 1'b0, 1'b0);
    stall_row = -1; stall_len = 0;
    checks++; if (nwr != 4)      begin errors++; $display("FAIL bp_writes: got %0d expected 4", nwr); end
    checks++; if (unstable != 0) begin errors++; $display("FAIL bp_stable: got %0d changes expected 0", unstable); end
    checks++; if (vdrop != 0)    begin errors++; $display("FAIL bp_valid_drop: got %0d expected 0", vdrop); end
    checks++; if (lat != 22)     begin errors++; $display("FAIL bp_latency: got %0d expected 22", lat); end
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (got[r] !== t1_row(r, 1)) begin errors++; $display("FAIL bp_row%0d: got %h expected %h", r, got[r], t1_row(r, 1)); end
    end
  endtask

  task automatic test_accumulate();
    load_t1();
    run_job(4, 1'b0, 1'b0);
    run_job(4, 1'b0, 1'b1);
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (got[r] !== t1_row(r, 2)) begin errors++; $display("FAIL acc_row%0d: got %h expected %h", r, got[r], t1_row(r, 2)); end
    end
    run_job(0, 1'b0, 1'b1);
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (got[r] !== t1_row(r, 2)) begin errors++; $display("FAIL acc_k0_row%0d: got %h expected %h", r, got[r], t1_row(r, 2)); end
    end
  endtask

  task automatic test_wrap8();
    int v, n8, seen;
    logic [31:0] g8 [4];
    logic [7:0] e;
    v = 2 * 255 * 255;
    e = v[7:0];
    n8 = 0; seen = 0;
    for (int r = 0; r < 4; r++) g8[r] = 32'h5A5A_5A5A;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int cyc = 1; cyc < 200 && seen == 0; cyc++) begin
      if (c_valid8) begin g8[c_addr8] = c_data8; n8++; end
      if (done8) seen = 1;
      @(negedge clk);
    end
    checks++; if (seen != 1 || n8 != 4) begin errors++; $display("FAIL wrap8_job: got done=%0d writes=%0d expected 1 4", seen, n8); end
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (g8[r] !== {4{e}}) begin errors++; $display("FAIL wrap8_row%0d: got %h expected %h", r, g8[r], {4{e}}); end
    end
  endtask

  task automatic test_abort();
    load_t1();
    k_len = 8'd4; signed_mode = 1'b0; acc_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_pre_busy: got %b expected 1", busy); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || c_valid !== 1'b0 || done !== 1'b0)
      begin errors++; $display("FAIL abort_outputs: got busy=%b c_valid=%b done=%b expected 0 0 0", busy, c_valid, done); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_job(4, 1'b0, 1'b0);
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL abort_done_count: got %0d expected 1", done_cnt); end
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (got[r] !== t1_row(r, 1)) begin errors++; $display("FAIL abort_row%0d: got %h expected %h", r, got[r], t1_row(r, 1)); end
    end
  endtask

  task automatic test_start_ignored();
    load_t1();
    poke_at = 5;
    run_job(4, 1'b0, 1'b1);
    poke_at = -1;
    checks++; if (lat != 17) begin errors++; $display("FAIL restart_latency: got %0d expected 17", lat); end
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (got[r] !== t1_row(r, 2)) begin errors++; $display("FAIL restart_row%0d: got %h expected %h", r, got[r], t1_row(r, 2)); end
    end
  endtask

  initial begin
    for (int k = 0; k < 256; k++) begin a_mem[k] = '0; b_mem[k] = '0; end
    test_reset();
    test_identity();
    test_signed();
    test_kzero();
    test_backpressure();
    test_accumulate();
    test_wrap8();
    test_abort();
    test_start_ignored();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
